// File: rtl/fft_pkg.sv
// Shared types and fixed-point constants for the FFT butterfly blocks.
// The functions give the same constants for component widths other than the default.
package fft_pkg;

  localparam int DW_DEFAULT = 16;

  typedef struct packed {
    logic signed [DW_DEFAULT-1:0] re;
    logic signed [DW_DEFAULT-1:0] im;
  } cplx_t;

  function automatic int qshift(input int dw);
    return dw - 1;
  endfunction

  // Half an LSB of the Q1.(dw-1) product, added before the truncating shift.
  function automatic longint round_k(input int dw);
    return longint'(1) << (dw - 2);
  endfunction

  localparam int     QSHIFT  = qshift(DW_DEFAULT);
  localparam longint ROUND_C = round_k(DW_DEFAULT);

endpackage

// File: rtl/butterfly_inv_if.sv
// Handshake and data bundle of the inverse butterfly: input side x/y/w, output side a/b.
interface butterfly_inv_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic          in_ready;
  logic [2*DW-1:0] x;
  logic [2*DW-1:0] y;
  logic [2*DW-1:0] w;
  logic          out_valid;
  logic          out_ready;
  logic [2*DW-1:0] a;
  logic [2*DW-1:0] b;
  logic          ovf;

  modport master (
    output in_valid, x, y, w, out_ready,
    input  in_ready, out_valid, a, b, ovf
  );

  modport slave (
    input  in_valid, x, y, w, out_ready,
    output in_ready, out_valid, a, b, ovf
  );
endinterface

// File: rtl/butterfly_inv_cmul.sv
// cmul: registered four-product stage (S2) and round/reduce stage (S3) of d*conj(w).
// BUTTERFLY_INV_SAT_EN selects clamping with a sticky ovf; otherwise results wrap.
module cmul
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] d_re,
  input  logic signed [DW-1:0] d_im,
  input  logic signed [DW-1:0] wc_re,
  input  logic signed [DW-1:0] wc_im,
  output logic                 out_valid,
  output logic [2*DW-1:0]      b,
  output logic                 ovf
);
  localparam int PW = 2 * DW;
  localparam int SW = 2 * DW + 1;
  localparam int QS = qshift(DW);
  localparam logic signed [SW-1:0] RND   = SW'(round_k(DW));
  localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic                 v2;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] s_re, s_im, r_re, r_im;
  logic signed [DW-1:0] q_re, q_im;

  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else if (en) v2 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      p_rr <= PW'(d_re) * PW'(wc_re);
      p_ii <= PW'(d_im) * PW'(wc_im);
      p_ri <= PW'(d_re) * PW'(wc_im);
      p_ir <= PW'(d_im) * PW'(wc_re);
    end
  end

  assign s_re = SW'(p_rr) - SW'(p_ii);
  assign s_im = SW'(p_ri) + SW'(p_ir);
  assign r_re = (s_re + RND) >>> QS;
  assign r_im = (s_im + RND) >>> QS;

`ifdef BUTTERFLY_INV_SAT_EN
  logic inr_re, inr_im;

  assign inr_re = (r_re >= SW'(MIN_V)) && (r_re <= SW'(MAX_V));
  assign inr_im = (r_im >= SW'(MIN_V)) && (r_im <= SW'(MAX_V));
  assign q_re   = inr_re ? DW'(r_re) : (r_re[SW-1] ? MIN_V : MAX_V);
  assign q_im   = inr_im ? DW'(r_im) : (r_im[SW-1] ? MIN_V : MAX_V);

  // Only results actually entering S3 may set the flag, never bubbles.
  always_ff @(posedge clk) begin
    if (rst) ovf <= 1'b0;
    else if (en && v2 && !(inr_re && inr_im)) ovf <= 1'b1;
  end
`else
  assign q_re = DW'(r_re);
  assign q_im = DW'(r_im);
  assign ovf  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      b         <= '0;
    end else if (en) begin
      out_valid <= v2;
      b         <= {q_re, q_im};
    end
  end

endmodule

// File: rtl/butterfly_inv.sv
// butterfly_inv: undoes a radix-2 butterfly, a = (x+y)/2, b = ((x-y)/2)*conj(w), 3-cycle pipeline.
// Define BUTTERFLY_INV_SAT_EN to clamp b and raise the sticky ovf; otherwise b wraps.
module butterfly_inv
  import fft_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  butterfly_inv_if.slave bus
);
  localparam logic signed [DW-1:0] MAX_V = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_V = {1'b1, {(DW-1){1'b0}}};

  logic signed [DW-1:0] x_re, x_im, y_re, y_im, w_re, w_im, wc_im;
  logic signed [DW:0]   sum_re, sum_im, dif_re, dif_im;
  logic signed [DW-1:0] a1_re, a1_im, d1_re, d1_im, wc1_re, wc1_im;
  logic [2*DW-1:0]      a2, a3, b3;
  logic                 v1, v3, ovf_q;
  logic                 stall, en;

  assign {x_re, x_im} = bus.x;
  assign {y_re, y_im} = bus.y;
  assign {w_re, w_im} = bus.w;

  assign sum_re = {x_re[DW-1], x_re} + {y_re[DW-1], y_re};
  assign sum_im = {x_im[DW-1], x_im} + {y_im[DW-1], y_im};
  assign dif_re = {x_re[DW-1], x_re} - {y_re[DW-1], y_re};
  assign dif_im = {x_im[DW-1], x_im} - {y_im[DW-1], y_im};

  // -MIN has no DW-bit representation, so it pins to MAX.
  assign wc_im = (w_im == MIN_V) ? MAX_V : -w_im;

  // Whole pipeline freezes only when a finished result is refused; reset always lets it flush.
  assign stall = v3 && !bus.out_ready && !rst;
  assign en    = !stall;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else if (en) v1 <= bus.in_valid;
  end

  always_ff @(posedge clk) begin
    if (en) begin
      a1_re  <= DW'(sum_re >>> 1);
      a1_im  <= DW'(sum_im >>> 1);
      d1_re  <= DW'(dif_re >>> 1);
      d1_im  <= DW'(dif_im >>> 1);
      wc1_re <= w_re;
      wc1_im <= wc_im;
      a2     <= {a1_re, a1_im};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) a3 <= '0;
    else if (en) a3 <= a2;
  end

  cmul #(.DW(DW)) u_cmul (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (v1),
    .d_re      (d1_re),
    .d_im      (d1_im),
    .wc_re     (wc1_re),
    .wc_im     (wc1_im),
    .out_valid (v3),
    .b         (b3),
    .ovf       (ovf_q)
  );

  assign bus.in_ready  = !stall;
  assign bus.out_valid = v3;
  assign bus.a         = a3;
  assign bus.b         = b3;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/butterfly_inv.md
BUTTERFLY_INV -- requirements
Module: butterfly_inv

Interface
REQ-001 The block SHALL have one parameter: DW, default 16, giving the width of each real and imaginary component.
REQ-002 `clk`  input  1  is the single clock; all state updates on its rising edge.
REQ-003 `rst`  input  1  is a synchronous, active-high reset.
REQ-004 `in_valid`  input  1  qualifies `x`, `y` and `w`.
REQ-005 `in_ready`  output  1  indicates the block accepts an input this cycle.
REQ-006 `x`  input  2*DW  is the forward-butterfly sum output, packed as {re, im}, signed integer.
REQ-007 `y`  input  2*DW  is the forward-butterfly difference output, packed as {re, im}, signed integer.
REQ-008 `w`  input  2*DW  is the twiddle used by the forward butterfly, packed as {re, im}, signed Q1.(DW-1).
REQ-009 `out_valid`  output  1  qualifies `a` and `b`.
REQ-010 `out_ready`  input  1  is downstream acceptance.
REQ-011 `a`  output  2*DW  is the recovered first operand, packed as {re, im}.
REQ-012 `b`  output  2*DW  is the recovered second operand, packed as {re, im}.
REQ-013 `ovf`  output  1  is a sticky saturation flag.

Function
REQ-014 The block SHALL invert the forward butterfly, with a = (x+y)/2 and b = ((x-y)/2)*conj(w); this is exact for |w|=1.
REQ-015 Sum and difference SHALL be computed at DW+1 bits, then arithmetically shifted right by 1 (floor), giving a DW-bit result.
REQ-016 conj(w) SHALL negate the imaginary part; negating -2^(DW-1) SHALL yield 2^(DW-1)-1.
REQ-017 The complex product SHALL form four DW x DW products at full 2*DW width and sum each pair at 2*DW+1 bits.
REQ-018 Each product sum SHALL be rounded by adding 2^(DW-2) and then arithmetically shifting right by DW-1.
REQ-019 The block SHALL be a 3-stage pipeline: S1 computes sum, difference and conj(w); S2 registers the four products; S3 performs the rounding and final width reduction.
REQ-020 Latency SHALL be exactly 3 cycles from input acceptance to `out_valid`, with one result per cycle sustained while `out_ready` is high.
REQ-021 A transfer SHALL occur on a cycle where valid and ready are both high; the block SHALL accept no input when `in_valid` is low.
REQ-022 Stall condition: stall = out_valid && !out_ready.
  - `in_ready` SHALL equal !stall.
  - During a stall every stage and its valid bit SHALL hold.
REQ-023 While `out_valid` is high and `out_ready` is low, `a` and `b` SHALL be stable.
REQ-024 Bubbles SHALL propagate; a stage with valid=0 SHALL not block the stages upstream of it (full-pipeline flow, no gaps inserted).
REQ-025 An input and an output transfer in the same cycle SHALL both complete with no loss or duplication.
REQ-026 `a` needs no a-path saturation since the floor halving already fits DW bits; the `a` path SHALL nevertheless be delayed so that `a` aligns with `b`.

Reset
REQ-027 On `rst`, all pipeline valid bits and `ovf` SHALL clear to 0, and `a`, `b` SHALL be 0 on the next cycle.
REQ-028 `in_ready` SHALL be 1 during reset and in the first cycle after reset.
REQ-029 Reset mid-operation SHALL discard all in-flight data, and no `out_valid` SHALL appear for pre-reset inputs.
REQ-030 Datapath registers other than those named in REQ-027 need not reset.

Configuration
REQ-031 Macro BUTTERFLY_INV_SAT_EN controls how `b` components outside the DW range are reduced.
  - Defined: out-of-range components SHALL clamp to [-2^(DW-1), 2^(DW-1)-1], and `ovf` SHALL set and stay set until `rst`.
  - Undefined: components SHALL wrap (two's-complement truncation), and `ovf` SHALL be tied to 0.

Structure
REQ-032 Package fft_pkg SHALL hold:
  - DW_DEFAULT;
  - typedef cplx_t, a packed struct {logic signed [DW-1:0] re, im};
  - the Q-format shift constant QSHIFT = DW-1;
  - the rounding constant.
REQ-033 Sub-module cmul SHALL implement the registered four-product stage and the combine/round stage; butterfly_inv SHALL contain S1, the handshake and the a-path delay.

Verification
REQ-034 Scenario 1: x=32'h022BFCF7, y=32'h006F00DB, w=32'h00008000 (-j) -> after 3 cycles a=32'h014DFEE9 (333-279j) and b=32'h01F200DE (498+222j).
REQ-035 Scenario 2: same x, y with w=32'h00007FFF (~+j) -> a=32'h014DFEE9 and b=32'hFE0EFF22 (-498-222j).
REQ-036 Scenario 3: w=32'h7FFF0000 (1), x=32'h00030001, y=32'h00010000 -> a=32'h00020000 (floor of (4,1)/2) and b=32'h00010000.
REQ-037 Scenario 4: 8 back-to-back inputs, `out_ready` low on cycles 5-7 -> `in_ready` falls on the same cycles; all 8 outputs are delivered in order, none lost or duplicated, and outputs are held stable while stalled.
REQ-038 Scenario 5: x=32'h80000000, y=32'h7FFF0000, w=32'h80000000 (-1) -> b.re saturates to 32767 and `ovf`=1 with the macro defined, and wraps with `ovf`=0 with it undefined.
REQ-039 Scenario 6: assert `rst` with 2 stages valid -> `out_valid`=0 next cycle and no stale outputs thereafter; `ovf`=0.
